riscv_core_immgen_pipe: RTL and testbench
=========================================

Name: riscv_core_immgen_pipe

Overview:
- Registered, handshaked immediate generator for the RV64IMAC decode stage.
- Takes a full 32-bit instruction word plus an immediate-format select from the main decoder and produces an XLEN-wide extended immediate.
- Results sit in a DEPTH-entry output FIFO with valid/ready on both sides, so decode-to-execute stalls are decoupled.
- Adds a shamt format, an illegal-format flag, tag passthrough, flush, and optional compressed (RVC) formats.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
DEPTH, 2, output FIFO entries; power of two, at least 2.
TAG_W, 5, width of the sideband tag carried alongside each result.

Ports:
i_immgen_clk  input  1  clock, rising edge
i_immgen_rst_n  input  1  asynchronous active-low reset
i_immgen_flush  input  1  synchronous flush; empties the FIFO
i_immgen_valid  input  1  request valid
o_immgen_ready  output  1  request can be accepted
i_immgen_instr  input  32  instruction word; RVC formats use [15:0]
i_immgen_immsrc  input  4  format select
i_immgen_tag  input  TAG_W  sideband tag, returned unchanged
o_immgen_valid  output  1  result valid (FIFO head)
i_immgen_ready  input  1  consumer accepts the result
o_immgen_imm  output  XLEN  extended immediate
o_immgen_tag  output  TAG_W  tag of the result
o_immgen_illegal  output  1  immsrc was an unsupported code

Behaviour:
- Reset (async assert, sync release): write pointer, read pointer and count go to 0. Outputs after reset: o_immgen_valid=0, o_immgen_ready=1.
- Whenever o_immgen_valid=0, o_immgen_imm, o_immgen_tag and o_immgen_illegal read 0. Storage contents are not reset.
- Formats; bit positions refer to instr, sext/zext are to XLEN:
  - 0 I: sext [31:20].
  - 1 S: sext {[31:25],[11:7]}.
  - 2 B: sext {[31],[7],[30:25],[11:8],0}.
  - 3 J: sext {[31],[19:12],[20],[30:21],0}.
  - 4 U: sext {[31:12],12'b0}. For XLEN=32 there is no extension.
  - 5 AMO: all zeros.
  - 6 CSR zimm: zext [19:15].
  - 7 shamt: zext [25:20] when XLEN=64, zext [24:20] when XLEN=32.
  - 8-11: RVC formats (see Optional Feature).
  - 12-15: illegal.
- Illegal format: imm=0 and illegal=1 are stored with the entry. This is not an error stall; the entry flows through normally.
- Push: occurs when i_immgen_valid && o_immgen_ready && !i_immgen_flush. The immediate is computed combinationally and written to storage at that edge.
- Pop: occurs when o_immgen_valid && i_immgen_ready.
- Ready: o_immgen_ready = (count != DEPTH). It is registered-state based and has no combinational path from i_immgen_ready.
- Latency: a push into an empty FIFO at edge N gives o_immgen_valid=1 after edge N, i.e. a result is visible 1 cycle after acceptance.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal whenever not full.
- Full FIFO: no push is possible, even if a pop happens in the same cycle. Requesters see ready=1 one cycle later.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH and uses $clog2(DEPTH)+1 bits.
- Flush: sets pointers and count to 0 at the next edge and discards any push in that cycle.
  - o_immgen_valid=0 after that edge.
  - A pop in the same cycle still completes for the consumer that sampled it.
- Reset mid-operation: all entries are lost immediately (asynchronous reset), and o_immgen_valid drops without waiting for a clock.
- Input stability: the sender holds instr, immsrc and tag stable while valid && !ready. The block does not check this.

Optional Feature:
- Macro: RISCV_CORE_IMMGEN_RVC_EN.
- When defined, codes 8-11 decode RVC immediates from [15:0]:
  - 8 CI: sext {[12],[6:2]}.
  - 9 CJ: sext, where imm[11]=[12], [10]=[8], [9:8]=[10:9], [7]=[6], [6]=[7], [5]=[2], [4]=[11], [3:1]=[5:3], [0]=0.
  - 10 CB: sext, where imm[8]=[12], [7:6]=[6:5], [5]=[2], [4:3]=[11:10], [2:1]=[4:3], [0]=0.
  - 11 CIW: zext, where imm[9:6]=[10:7], [5:4]=[12:11], [3]=[5], [2]=[6], [1:0]=0.
- When not defined, codes 8-11 are illegal (imm=0, illegal=1) and no RVC decode logic is built.

Test Plan:
- XLEN=64, consumer always ready. Send 0xFFF00093 with immsrc=0, tag=3. Next cycle expect valid=1, imm=0xFFFFFFFFFFFFFFFF, tag=3, illegal=0.
- Back-to-back 0x0020B423/S, 0xFE000EE3/B, 0x800000B7/U. Expect 0x8, then 0xFFFFFFFFFFFFFFFC, then 0xFFFFFFFF80000000, in order, one per cycle.
- DEPTH=2, i_immgen_ready=0, push 3 requests.
  - ready=0 after the 2nd push; the 3rd is held.
  - Raise i_immgen_ready: results drain in order, and the 3rd is accepted the cycle after the first pop.
- Send immsrc=6 with [19:15]=0x1F: expect 31. Send immsrc=13: expect imm=0, illegal=1. Send immsrc=7 with [25:20]=0x3F: expect 63.
- Fill the FIFO, assert flush while pushing: valid=0 next cycle and the pushed entry never appears. Separately, assert reset with 1 entry held: valid=0 immediately, ready=1.
- With RISCV_CORE_IMMGEN_RVC_EN defined, send 0x10FD with immsrc=8: expect 0xFFFFFFFFFFFFFFFF. Without the macro: expect imm=0, illegal=1.

Source files
------------

// File: rtl/riscv_core_immgen_pipe_if.sv
// riscv_core_immgen_pipe_if: request/result handshake bundle for the immediate generator
interface riscv_core_immgen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             i_immgen_flush;
  logic             i_immgen_valid;
  logic             o_immgen_ready;
  logic [31:0]      i_immgen_instr;
  logic [3:0]       i_immgen_immsrc;
  logic [TAG_W-1:0] i_immgen_tag;
  logic             o_immgen_valid;
  logic             i_immgen_ready;
  logic [XLEN-1:0]  o_immgen_imm;
  logic [TAG_W-1:0] o_immgen_tag;
  logic             o_immgen_illegal;
  modport master (
    output i_immgen_flush, i_immgen_valid, i_immgen_instr, i_immgen_immsrc, i_immgen_tag, i_immgen_ready,
    input  o_immgen_ready, o_immgen_valid, o_immgen_imm, o_immgen_tag, o_immgen_illegal
  );
  modport slave (
    input  i_immgen_flush, i_immgen_valid, i_immgen_instr, i_immgen_immsrc, i_immgen_tag, i_immgen_ready,
    output o_immgen_ready, o_immgen_valid, o_immgen_imm, o_immgen_tag, o_immgen_illegal
  );
endinterface

// File: rtl/riscv_core_immgen_pipe.sv
// riscv_core_immgen_pipe: registered immediate generator with a DEPTH-entry valid/ready output FIFO
// Define RISCV_CORE_IMMGEN_RVC_EN to decode the compressed formats on immsrc 8-11.
module riscv_core_immgen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input logic                      i_immgen_clk,
  input logic                      i_immgen_rst_n,
  riscv_core_immgen_pipe_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             ill_mem [DEPTH];
  logic [31:0]      in;
  logic [XLEN-1:0]  imm;
  logic             ill, push, pop, unused_ok;
  assign in        = bus.i_immgen_instr;
  assign unused_ok = ^in[6:0];
  always_comb begin
    imm = '0;
    ill = 1'b0;
    case (bus.i_immgen_immsrc)
      4'd0: imm = XLEN'($signed(in[31:20]));
      4'd1: imm = XLEN'($signed({in[31:25], in[11:7]}));
      4'd2: imm = XLEN'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
      4'd3: imm = XLEN'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
      4'd4: imm = XLEN'($signed({in[31:12], 12'b0}));
      4'd5: imm = '0;
      4'd6: imm = XLEN'(in[19:15]);
      4'd7: imm = XLEN == 64 ? XLEN'(in[25:20]) : XLEN'(in[24:20]);
`ifdef RISCV_CORE_IMMGEN_RVC_EN
      4'd8: imm = XLEN'($signed({in[12], in[6:2]}));
      4'd9: imm = XLEN'($signed({in[12], in[8], in[10:9], in[6], in[7], in[2], in[11], in[5:3], 1'b0}));
      4'd10: imm = XLEN'($signed({in[12], in[6:5], in[2], in[11:10], in[4:3], 1'b0}));
      4'd11: imm = XLEN'({in[10:7], in[12:11], in[5], in[6], 2'b0});
`endif
      default: ill = 1'b1;
    endcase
  end
  assign bus.o_immgen_ready = count != FULL;
  assign bus.o_immgen_valid = count != '0;
  assign push = bus.i_immgen_valid && bus.o_immgen_ready && !bus.i_immgen_flush;
  assign pop  = bus.o_immgen_valid && bus.i_immgen_ready;
  always_ff @(posedge i_immgen_clk or negedge i_immgen_rst_n) begin
    if (!i_immgen_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.i_immgen_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  // Storage is deliberately unreset; the count gates every read.
  always_ff @(posedge i_immgen_clk) begin
    if (push) begin
      imm_mem[wr_ptr] <= imm;
      tag_mem[wr_ptr] <= bus.i_immgen_tag;
      ill_mem[wr_ptr] <= ill;
    end
  end
  assign bus.o_immgen_imm     = bus.o_immgen_valid ? imm_mem[rd_ptr] : '0;
  assign bus.o_immgen_tag     = bus.o_immgen_valid ? tag_mem[rd_ptr] : '0;
  assign bus.o_immgen_illegal = bus.o_immgen_valid && ill_mem[rd_ptr];
endmodule

// File: tb/tb_riscv_core_immgen_pipe.sv
// tb_riscv_core_immgen_pipe: directed and randomized checks against an arithmetic immediate model
module tb_riscv_core_immgen_pipe;
  typedef struct packed {logic [63:0] imm; logic [4:0] tag; logic ill;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  riscv_core_immgen_pipe_if #(.XLEN(64), .TAG_W(5)) bus ();
  riscv_core_immgen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5)) dut (
    .i_immgen_clk(clk), .i_immgen_rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
    logic [31:0] m;
    m = (32'h1 << (hi - lo + 1)) - 32'h1;
    return longint'((w >> lo) & m);
  endfunction

  // Immediate value as a signed number built from weighted instruction fields.
  function automatic ent_t model(input logic [31:0] w, input logic [3:0] src, input logic [4:0] tag);
    longint v;
    ent_t e;
    v = 0;
    e.ill = 1'b0;
    case (src)
      4'd0: v = fld(w, 31, 20) - fld(w, 31, 31) * 4096;
      4'd1: v = fld(w, 31, 25) * 32 + fld(w, 11, 7) - fld(w, 31, 31) * 4096;
      4'd2: v = fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2 - fld(w, 31, 31) * 4096;
      4'd3: v = fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2 - fld(w, 31, 31) * 1048576;
      4'd4: v = fld(w, 31, 12) * 4096 - fld(w, 31, 31) * (longint'(1) << 32);
      4'd5: v = 0;
      4'd6: v = fld(w, 19, 15);
      4'd7: v = fld(w, 25, 20);
`ifdef RISCV_CORE_IMMGEN_RVC_EN
      4'd8: v = fld(w, 6, 2) - fld(w, 12, 12) * 32;
      4'd9: v = fld(w, 8, 8) * 1024 + fld(w, 10, 9) * 256 + fld(w, 6, 6) * 128 + fld(w, 7, 7) * 64
              + fld(w, 2, 2) * 32 + fld(w, 11, 11) * 16 + fld(w, 5, 3) * 2 - fld(w, 12, 12) * 2048;
      4'd10: v = fld(w, 6, 5) * 64 + fld(w, 2, 2) * 32 + fld(w, 11, 10) * 8 + fld(w, 4, 3) * 2 - fld(w, 12, 12) * 256;
      4'd11: v = fld(w, 10, 7) * 64 + fld(w, 12, 11) * 16 + fld(w, 5, 5) * 8 + fld(w, 6, 6) * 4;
`endif
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v);
    e.tag = tag;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [3:0] s, input logic [4:0] t);
    bus.i_immgen_valid  = v;
    bus.i_immgen_instr  = w;
    bus.i_immgen_immsrc = s;
    bus.i_immgen_tag    = t;
  endtask

  task automatic test_reset;
    bus.i_immgen_flush = 1'b0;
    bus.i_immgen_ready = 1'b0;
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal} !== {1'b0, 1'b1, 64'h0, 5'h0, 1'b0})
      begin miscompares++; $display("FAIL reset_state: valid=%b ready=%b imm=%h tag=%h ill=%b, need 0 1 0 0 0",
        bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.o_immgen_valid, bus.o_immgen_ready} !== 2'b01)
      begin miscompares++; $display("FAIL after_release: valid=%b ready=%b, need 0 1", bus.o_immgen_valid, bus.o_immgen_ready); end
  endtask

  task automatic test_basic;
    ent_t e;
    bus.i_immgen_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 4'd0, 5'd3);
    e = model(32'hFFF00093, 4'd0, 5'd3);
    @(negedge clk);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    vectors++;
    if ({bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal} !== {1'b1, e} || e.imm !== 64'hFFFFFFFFFFFFFFFF)
      begin miscompares++; $display("FAIL basic_i: valid=%b imm=%h tag=%0d ill=%b, need 1 %h %0d %b",
        bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal, e.imm, e.tag, e.ill); end
    @(negedge clk);
    vectors++;
    if (bus.o_immgen_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: valid=%b, need 0", bus.o_immgen_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [3] = '{32'h0020B423, 32'hFE000EE3, 32'h800000B7};
    logic [3:0]  s [3] = '{4'd1, 4'd2, 4'd4};
    logic [63:0] k [3] = '{64'h8, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000};
    ent_t e;
    bus.i_immgen_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        e = model(w[i-1], s[i-1], 5'(i + 10));
        vectors++;
        if ({bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag} !== {1'b1, k[i-1], 5'(i + 10)} || e.imm !== k[i-1])
          begin miscompares++; $display("FAIL b2b_%0d: valid=%b imm=%h tag=%0d, need 1 %h %0d (model %h)",
            i - 1, bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, k[i-1], i + 10, e.imm); end
      end
      if (i < 3) drive(1'b1, w[i], s[i], 5'(i + 11));
      else drive(1'b0, 32'h0, 4'd0, 5'd0);
      @(negedge clk);
    end
    vectors++;
    if (bus.o_immgen_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: valid=%b, need 0", bus.o_immgen_valid); end
  endtask

  task automatic test_backpressure;
    ent_t e [3];
    logic [31:0] w;
    for (int i = 0; i < 3; i++) e[i] = model(32'h12345678 + 32'(i) * 32'h01010101, 4'(i + 1), 5'(i + 7));
    bus.i_immgen_ready = 1'b0;
    drive(1'b1, 32'h12345678, 4'd1, 5'd7);
    @(negedge clk);
    vectors++;
    if (bus.o_immgen_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready1: ready=%b, need 1", bus.o_immgen_ready); end
    w = 32'h12345678 + 32'h01010101;
    drive(1'b1, w, 4'd2, 5'd8);
    @(negedge clk);
    vectors++;
    if ({bus.o_immgen_ready, bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal} !== {2'b01, e[0]})
      begin miscompares++; $display("FAIL bp_full: ready=%b valid=%b imm=%h tag=%0d, need 0 1 %h %0d",
        bus.o_immgen_ready, bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, e[0].imm, e[0].tag); end
    w = 32'h12345678 + 32'h02020202;
    drive(1'b1, w, 4'd3, 5'd9);
    @(negedge clk);
    vectors++;
    if (bus.o_immgen_ready !== 1'b0) begin miscompares++; $display("FAIL bp_held: ready=%b, need 0", bus.o_immgen_ready); end
    bus.i_immgen_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.o_immgen_ready, bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal} !== {2'b11, e[1]})
      begin miscompares++; $display("FAIL bp_pop1: ready=%b valid=%b imm=%h tag=%0d, need 1 1 %h %0d",
        bus.o_immgen_ready, bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, e[1].imm, e[1].tag); end
    @(negedge clk);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    vectors++;
    if ({bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal} !== {1'b1, e[2]})
      begin miscompares++; $display("FAIL bp_third: valid=%b imm=%h tag=%0d, need 1 %h %0d",
        bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_tag, e[2].imm, e[2].tag); end
    @(negedge clk);
    vectors++;
    if (bus.o_immgen_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: valid=%b, need 0", bus.o_immgen_valid); end
  endtask

  task automatic test_formats;
    logic [31:0] w [3] = '{32'h000F8000, 32'hFFFFFFFF, 32'h03F00000};
    logic [3:0]  s [3] = '{4'd6, 4'd13, 4'd7};
    logic [64:0] k [3] = '{{64'd31, 1'b0}, {64'd0, 1'b1}, {64'd63, 1'b0}};
    bus.i_immgen_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        vectors++;
        if ({bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_illegal} !== {1'b1, k[i-1]})
          begin miscompares++; $display("FAIL fmt_src%0d: valid=%b imm=%h ill=%b, need 1 %h %b",
            s[i-1], bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_illegal, k[i-1][64:1], k[i-1][0]); end
      end
      if (i < 3) drive(1'b1, w[i], s[i], 5'd1);
      else drive(1'b0, 32'h0, 4'd0, 5'd0);
      @(negedge clk);
    end
  endtask

  task automatic test_flush;
    ent_t e;
    bus.i_immgen_ready = 1'b0;
    drive(1'b1, 32'h00100093, 4'd0, 5'd1);
    @(negedge clk);
    drive(1'b1, 32'h00200093, 4'd0, 5'd2);
    @(negedge clk);
    bus.i_immgen_flush = 1'b1;
    drive(1'b1, 32'h00300093, 4'd0, 5'd3);
    @(negedge clk);
    bus.i_immgen_flush = 1'b0;
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    vectors++;
    if ({bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm} !== {2'b01, 64'h0})
      begin miscompares++; $display("FAIL flush_full: valid=%b ready=%b imm=%h, need 0 1 0", bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm); end
    drive(1'b1, 32'h00400093, 4'd0, 5'd4);
    @(negedge clk);
    bus.i_immgen_flush = 1'b1;
    drive(1'b1, 32'h00500093, 4'd0, 5'd5);
    @(negedge clk);
    bus.i_immgen_flush = 1'b0;
    drive(1'b1, 32'h00600093, 4'd0, 5'd6);
    vectors++;
    if (bus.o_immgen_valid !== 1'b0) begin miscompares++; $display("FAIL flush_push: valid=%b, need 0", bus.o_immgen_valid); end
    @(negedge clk);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    e = model(32'h00600093, 4'd0, 5'd6);
    vectors++;
    if ({bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm, bus.o_immgen_tag} !== {2'b11, e.imm, e.tag})
      begin miscompares++; $display("FAIL flush_after: valid=%b ready=%b imm=%h tag=%0d, need 1 1 %h %0d",
        bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm, bus.o_immgen_tag, e.imm, e.tag); end
    bus.i_immgen_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    bus.i_immgen_ready = 1'b0;
    drive(1'b1, 32'h7FF00093, 4'd0, 5'd9);
    @(negedge clk);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    vectors++;
    if (bus.o_immgen_valid !== 1'b1) begin miscompares++; $display("FAIL areset_held: valid=%b, need 1", bus.o_immgen_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm, bus.o_immgen_tag} !== {2'b01, 64'h0, 5'h0})
      begin miscompares++; $display("FAIL areset_now: valid=%b ready=%b imm=%h tag=%0d, need 0 1 0 0",
        bus.o_immgen_valid, bus.o_immgen_ready, bus.o_immgen_imm, bus.o_immgen_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rvc;
    bus.i_immgen_ready = 1'b1;
    drive(1'b1, 32'h000010FD, 4'd8, 5'd2);
    @(negedge clk);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    vectors++;
`ifdef RISCV_CORE_IMMGEN_RVC_EN
    if ({bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_illegal} !== {1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0})
`else
    if ({bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_illegal} !== {1'b1, 64'h0, 1'b1})
`endif
      begin miscompares++; $display("FAIL rvc_ci: valid=%b imm=%h ill=%b", bus.o_immgen_valid, bus.o_immgen_imm, bus.o_immgen_illegal); end
    @(negedge clk);
  endtask

  task automatic test_random;
    ent_t q [$];
    ent_t h;
    logic hold, push, pop, fl;
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      vectors++;
      if (bus.o_immgen_valid !== (q.size() != 0) || bus.o_immgen_ready !== (q.size() != 2))
        begin miscompares++; $display("FAIL rand_flags c=%0d: valid=%b ready=%b, need occupancy %0d", c, bus.o_immgen_valid, bus.o_immgen_ready, q.size()); end
      h = q.size() != 0 ? q[0] : '0;
      vectors++;
      if ({bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal} !== h)
        begin miscompares++; $display("FAIL rand_data c=%0d: imm=%h tag=%0d ill=%b, need %h %0d %b",
          c, bus.o_immgen_imm, bus.o_immgen_tag, bus.o_immgen_illegal, h.imm, h.tag, h.ill); end
      if (!hold) drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      bus.i_immgen_ready = $urandom_range(0, 2) != 0;
      fl = $urandom_range(0, 31) == 0;
      bus.i_immgen_flush = fl;
      push = bus.i_immgen_valid && q.size() != 2 && !fl;
      pop = q.size() != 0 && bus.i_immgen_ready;
      hold = bus.i_immgen_valid && !push;
      h = model(bus.i_immgen_instr, bus.i_immgen_immsrc, bus.i_immgen_tag);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (fl) q.delete();
      else if (push) q.push_back(h);
      @(negedge clk);
    end
    bus.i_immgen_flush = 1'b0;
    drive(1'b0, 32'h0, 4'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_formats();
    test_flush();
    test_async_reset();
    test_rvc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
